bypass_arbiter: RTL and testbench
=================================

Name: bypass_arbiter

Overview:
- Shares the single uncached (bypass) memory port of the standard data cache between NUM_REQ requesters, e.g. load unit, store/AMO unit and the miss handler.
- Round-robin arbitration with exactly one transaction outstanding at a time.
- Registers the winning request, presents it on the memory side with a req/gnt handshake, then routes the single-beat response back to the originating requester.
- Sits between the cache controllers and the miss handler's bypass interface.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ID_WIDTH, 4, width of the outbound transaction id; must satisfy ID_WIDTH >= $clog2(NUM_REQ)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
req_i  input  NUM_REQ  per-requester request
we_i  input  NUM_REQ  per-requester write enable
addr_i  input  NUM_REQ*64  per-requester address, requester k at [64k+63:64k]
wdata_i  input  NUM_REQ*64  per-requester write data
be_i  input  NUM_REQ*8  per-requester byte enables
size_i  input  NUM_REQ*2  per-requester size (0=byte..3=dword)
gnt_o  output  NUM_REQ  one-hot acceptance pulse
valid_o  output  NUM_REQ  one-hot response pulse
rdata_o  output  64  response data, shared by all requesters
mem_req_o  output  1  outbound request
mem_id_o  output  ID_WIDTH  index of the owning requester, zero-extended
mem_addr_o  output  64  registered address
mem_wdata_o  output  64  registered write data
mem_we_o  output  1  registered write enable
mem_be_o  output  8  registered byte enables
mem_size_o  output  2  registered size
mem_gnt_i  input  1  memory accepts mem_req_o
mem_valid_i  input  1  memory response valid
mem_rdata_i  input  64  memory response data
busy_o  output  1  state != IDLE
err_o  output  1  sticky: mem_valid_i seen outside WAIT

Behaviour:
- Reset (rst_i high at a clock edge):
  - State IDLE, round-robin pointer 0, all registered fields 0, err_o 0.
  - All outputs 0 the cycle after reset is sampled.
  - Reset mid-transaction abandons the transaction; no valid_o is issued for it.
- States IDLE, SEND, WAIT:
  - IDLE:
    - If req_i != 0, the winner is the first set bit at or after the pointer, searching upward with wrap from NUM_REQ-1 to 0.
    - gnt_o[winner] = 1 combinationally, same cycle.
    - Winner's fields and index are captured; pointer <= (winner+1) mod NUM_REQ; next state SEND.
    - If req_i == 0: stay in IDLE, gnt_o = 0.
  - SEND:
    - mem_req_o = 1; mem_* driven from the registers and held stable until mem_gnt_i.
    - mem_gnt_i && mem_valid_i in the same cycle: valid_o[idx] = 1, rdata_o = mem_rdata_i, next state IDLE.
    - mem_gnt_i alone: next state WAIT.
  - WAIT:
    - mem_req_o = 0.
    - On mem_valid_i: valid_o[idx] = 1 for exactly one cycle, rdata_o = mem_rdata_i, next state IDLE.
    - Wait is unbounded.
- Requests are not accepted in SEND or WAIT (gnt_o = 0); requesters hold req_i until granted.
- Minimum latency: grant at t, mem_req_o at t+1; with mem_gnt_i and mem_valid_i both at t+1, valid_o at t+1. A new grant is possible at t+2.
- rdata_o is 0 whenever valid_o == 0. Writes also return valid_o; rdata_o is don't-care for writes but must be driven from mem_rdata_i.
- mem_valid_i in IDLE, or in SEND without mem_gnt_i: ignored, err_o <= 1 (sticky until reset).
- mem_* outputs are 0 in IDLE.
- A requester that drops req_i without having been granted loses nothing; the pointer does not advance for it.

Test Plan:
- Reset with req_i=3'b111 asserted: all outputs 0 during reset; first cycle after reset gnt_o=3'b001.
- Single read from requester 1, addr=0x8000_0010, size=3; mem_gnt_i 2 cycles later, mem_valid_i 3 cycles after that with rdata=0xDEAD_BEEF_CAFE_F00D -> mem_id_o=1, mem_addr_o stable while waiting, valid_o=3'b010 for one cycle with that rdata.
- req_i=3'b111 held, memory grants and responds immediately -> grants in order 001, 010, 100, 001, one every 2 cycles.
- Same-cycle mem_gnt_i and mem_valid_i in SEND -> valid_o that cycle, state IDLE next cycle, no WAIT visit.
- mem_valid_i pulsed in IDLE -> err_o=1 and stays 1; no valid_o; the following transaction still completes normally.
- rst_i pulsed in WAIT, then mem_valid_i arrives -> no valid_o, err_o=1, busy_o=0.

Source files
------------

// File: rtl/bypass_arbiter_if.sv
// Requester-side and memory-side signals of the bypass arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface bypass_arbiter_if #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ID_WIDTH = 4
);
  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ-1:0]    we_i;
  logic [NUM_REQ*64-1:0] addr_i;
  logic [NUM_REQ*64-1:0] wdata_i;
  logic [NUM_REQ*8-1:0]  be_i;
  logic [NUM_REQ*2-1:0]  size_i;
  logic [NUM_REQ-1:0]    gnt_o;
  logic [NUM_REQ-1:0]    valid_o;
  logic [63:0]           rdata_o;
  logic                  mem_req_o;
  logic [ID_WIDTH-1:0]   mem_id_o;
  logic [63:0]           mem_addr_o;
  logic [63:0]           mem_wdata_o;
  logic                  mem_we_o;
  logic [7:0]            mem_be_o;
  logic [1:0]            mem_size_o;
  logic                  mem_gnt_i;
  logic                  mem_valid_i;
  logic [63:0]           mem_rdata_i;
  logic                  busy_o;
  logic                  err_o;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, be_i, size_i,
    input  mem_gnt_i, mem_valid_i, mem_rdata_i,
    output gnt_o, valid_o, rdata_o,
    output mem_req_o, mem_id_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o, mem_size_o,
    output busy_o, err_o
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, be_i, size_i,
    output mem_gnt_i, mem_valid_i, mem_rdata_i,
    input  gnt_o, valid_o, rdata_o,
    input  mem_req_o, mem_id_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o, mem_size_o,
    input  busy_o, err_o
  );
endinterface

// File: rtl/bypass_arbiter.sv
// Round-robin arbiter sharing the uncached bypass memory port between NUM_REQ
// requesters, with a single transaction outstanding at a time.
module bypass_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  bypass_arbiter_if.master bus
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, idx_q, win_idx;
  logic              win_found;
  int unsigned       cand;
  logic              capture, err_set;
  logic [NUM_REQ-1:0] gnt, valid;
  logic [63:0]       rdata;

  logic [63:0]       addr_q, wdata_q;
  logic              we_q;
  logic [7:0]        be_q;
  logic [1:0]        size_q;
  logic              err_q;
  logic              active;

  logic [63:0]       addr_a  [NUM_REQ];
  logic [63:0]       wdata_a [NUM_REQ];
  logic [7:0]        be_a    [NUM_REQ];
  logic [1:0]        size_a  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.addr_i[64*g +: 64];
    assign wdata_a[g] = bus.wdata_i[64*g +: 64];
    assign be_a[g]    = bus.be_i[8*g +: 8];
    assign size_a[g]  = bus.size_i[2*g +: 2];
  end

  // First requester at or after the pointer, wrapping at NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr_q) + i) % NUM_REQ;
      if (!win_found && bus.req_i[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    gnt     = '0;
    valid   = '0;
    rdata   = '0;
    capture = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt[win_idx] = 1'b1;
          capture      = 1'b1;
          state_d      = SEND;
        end
        if (bus.mem_valid_i) err_set = 1'b1;
      end
      SEND: begin
        if (bus.mem_gnt_i) begin
          if (bus.mem_valid_i) begin
            valid[idx_q] = 1'b1;
            rdata        = bus.mem_rdata_i;
            state_d      = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (bus.mem_valid_i) begin
          err_set = 1'b1;
        end
      end
      WAIT: begin
        if (bus.mem_valid_i) begin
          valid[idx_q] = 1'b1;
          rdata        = bus.mem_rdata_i;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Captured request fields, pointer and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (capture) begin
        idx_q   <= win_idx;
        addr_q  <= addr_a[win_idx];
        wdata_q <= wdata_a[win_idx];
        we_q    <= bus.we_i[win_idx];
        be_q    <= be_a[win_idx];
        size_q  <= size_a[win_idx];
        ptr_q   <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign active = (state_q != IDLE);

  // Grants and responses are suppressed while reset is asserted.
  assign bus.gnt_o       = rst_i ? '0 : gnt;
  assign bus.valid_o     = rst_i ? '0 : valid;
  assign bus.rdata_o     = rst_i ? '0 : rdata;
  assign bus.mem_req_o   = (state_q == SEND);
  assign bus.mem_id_o    = active ? ID_WIDTH'(idx_q) : '0;
  assign bus.mem_addr_o  = active ? addr_q  : '0;
  assign bus.mem_wdata_o = active ? wdata_q : '0;
  assign bus.mem_we_o    = active & we_q;
  assign bus.mem_be_o    = active ? be_q    : '0;
  assign bus.mem_size_o  = active ? size_q  : '0;
  assign bus.busy_o      = active;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_bypass_arbiter.sv
// Self-checking bench for bypass_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_bypass_arbiter;
  localparam int N   = 3;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bypass_arbiter_if #(.NUM_REQ(N), .ID_WIDTH(IDW)) bus ();

  bypass_arbiter #(.NUM_REQ(N), .ID_WIDTH(IDW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state: abstract transaction owner and phase.
  int          m_ptr;
  bit          m_busy, m_sent, m_err;
  int          m_owner;
  logic [63:0] m_addr, m_wdata;
  logic        m_we;
  logic [7:0]  m_be;
  logic [1:0]  m_size;

  typedef struct packed {
    logic       rst;
    logic [2:0] req;
    logic       mgnt;
    logic       mvalid;
    logic [2:0] gnt;
    logic [2:0] valid;
    logic       busy;
    logic       err;
    logic       mreq;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Rotate the request vector so the pointer is at bit 0, isolate the lowest set bit.
  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot, lsb;
    dbl = {r, r} >> p;
    rot = dbl[N-1:0];
    lsb = rot & (~rot + 1'b1);
    return (p + $clog2(lsb)) % N;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_busy = 0; m_sent = 0; m_err = 0; m_owner = 0;
    m_addr = '0; m_wdata = '0; m_we = 0; m_be = '0; m_size = '0;
  endtask

  task automatic model_check();
    logic [N-1:0] e_gnt, e_valid;
    logic [63:0]  e_rdata;
    e_gnt = '0; e_valid = '0; e_rdata = '0;
    if (!rst && !m_busy && bus.req_i != '0) e_gnt[2'(pick(bus.req_i, m_ptr))] = 1'b1;
    if (!rst && m_busy && bus.mem_valid_i && (m_sent || bus.mem_gnt_i)) begin
      e_valid[2'(m_owner)] = 1'b1;
      e_rdata = bus.mem_rdata_i;
    end
    chk("gnt",   64'(bus.gnt_o),   64'(e_gnt));
    chk("valid", 64'(bus.valid_o), 64'(e_valid));
    chk("rdata", bus.rdata_o,      e_rdata);
    chk("mem_req",   64'(bus.mem_req_o),  64'(m_busy && !m_sent));
    chk("mem_id",    64'(bus.mem_id_o),   m_busy ? 64'(m_owner) : 64'd0);
    chk("mem_addr",  bus.mem_addr_o,      m_busy ? m_addr : 64'd0);
    chk("mem_wdata", bus.mem_wdata_o,     m_busy ? m_wdata : 64'd0);
    chk("mem_we",    64'(bus.mem_we_o),   64'(m_busy && m_we));
    chk("mem_be",    64'(bus.mem_be_o),   m_busy ? 64'(m_be) : 64'd0);
    chk("mem_size",  64'(bus.mem_size_o), m_busy ? 64'(m_size) : 64'd0);
    chk("busy",      64'(bus.busy_o),     64'(m_busy));
    chk("err",       64'(bus.err_o),      64'(m_err));
  endtask

  task automatic model_update();
    int w;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (bus.mem_valid_i) m_err = 1;
      if (bus.req_i != '0) begin
        w       = pick(bus.req_i, m_ptr);
        m_owner = w;
        m_addr  = bus.addr_i[64*w +: 64];
        m_wdata = bus.wdata_i[64*w +: 64];
        m_we    = bus.we_i[w];
        m_be    = bus.be_i[8*w +: 8];
        m_size  = bus.size_i[2*w +: 2];
        m_ptr   = (w + 1) % N;
        m_busy  = 1;
        m_sent  = 0;
      end
    end else if (!m_sent) begin
      if (bus.mem_gnt_i) begin
        if (bus.mem_valid_i) m_busy = 0;
        else                 m_sent = 1;
      end else if (bus.mem_valid_i) begin
        m_err = 1;
      end
    end else if (bus.mem_valid_i) begin
      m_busy = 0;
      m_sent = 0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
    model_update();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic g, input logic v, input logic [63:0] d);
    bus.mem_gnt_i = g; bus.mem_valid_i = v; bus.mem_rdata_i = d;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_i = '0; bus.we_i = 3'b010;
    for (int k = 0; k < N; k++) begin
      bus.addr_i[64*k +: 64]  = 64'h1000 * 64'(k + 1);
      bus.wdata_i[64*k +: 64] = 64'h5555_0000_0000_0000 | 64'(k);
      bus.be_i[8*k +: 8]      = 8'hF0 | 8'(k);
      bus.size_i[2*k +: 2]    = 2'(k);
    end
    set_mem(1'b0, 1'b0, '0);
    model_reset();
    advance();

    //           rst   req     gnt   valid   gnt    valid   busy  err   mreq
    vecs[0]  = '{1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'b111, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'b111, 1'b1, 1'b1, 3'b000, 3'b001, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 3'b111, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'b111, 1'b1, 1'b1, 3'b000, 3'b010, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 3'b111, 1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'b111, 1'b1, 1'b1, 3'b000, 3'b100, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 3'b111, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'b111, 1'b0, 1'b1, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 3'b100, 1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 3'b000, 1'b1, 1'b1, 3'b000, 3'b100, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst;
      bus.req_i = vecs[i].req;
      set_mem(vecs[i].mgnt, vecs[i].mvalid, 64'hC0DE_0000_0000_0000 | 64'(i));
      sample();
      chk($sformatf("vec%0d_gnt", i),   64'(bus.gnt_o),     64'(vecs[i].gnt));
      chk($sformatf("vec%0d_valid", i), 64'(bus.valid_o),   64'(vecs[i].valid));
      chk($sformatf("vec%0d_busy", i),  64'(bus.busy_o),    64'(vecs[i].busy));
      chk($sformatf("vec%0d_err", i),   64'(bus.err_o),     64'(vecs[i].err));
      chk($sformatf("vec%0d_mreq", i),  64'(bus.mem_req_o), 64'(vecs[i].mreq));
      advance();
    end

    // Single read from requester 1 with slow grant and slow response.
    bus.we_i[1] = 1'b0;
    bus.addr_i[64 +: 64] = 64'h8000_0010;
    bus.size_i[2 +: 2]   = 2'd3;
    bus.req_i = 3'b010;
    set_mem(1'b0, 1'b0, '0);
    sample();
    chk("rd_gnt", 64'(bus.gnt_o), 64'(3'b010));
    advance();
    bus.req_i = 3'b000;
    for (int c = 0; c < 6; c++) begin
      set_mem(c == 2, c == 5, (c == 5) ? 64'hDEAD_BEEF_CAFE_F00D : 64'h0);
      sample();
      chk("rd_id",   64'(bus.mem_id_o),  64'd1);
      chk("rd_addr", bus.mem_addr_o,     64'h8000_0010);
      chk("rd_size", 64'(bus.mem_size_o), 64'd3);
      chk("rd_valid", 64'(bus.valid_o),  (c == 5) ? 64'(3'b010) : 64'd0);
      chk("rd_rdata", bus.rdata_o,       (c == 5) ? 64'hDEAD_BEEF_CAFE_F00D : 64'd0);
      advance();
    end
    set_mem(1'b0, 1'b0, '0);
    sample();
    chk("rd_after_valid", 64'(bus.valid_o), 64'd0);
    chk("rd_after_busy",  64'(bus.busy_o),  64'd0);
    advance();

    // Reset while waiting for the response abandons the transaction.
    bus.req_i = 3'b001;
    sample();
    chk("rw_gnt", 64'(bus.gnt_o), 64'(3'b001));
    advance();
    bus.req_i = 3'b000;
    set_mem(1'b1, 1'b0, '0);
    sample();
    advance();
    set_mem(1'b0, 1'b0, '0);
    rst = 1'b1;
    sample();
    chk("rw_rst_valid", 64'(bus.valid_o), 64'd0);
    advance();
    rst = 1'b0;
    set_mem(1'b0, 1'b1, 64'h1234);
    sample();
    chk("rw_late_valid", 64'(bus.valid_o), 64'd0);
    chk("rw_late_busy",  64'(bus.busy_o),  64'd0);
    advance();
    set_mem(1'b0, 1'b0, '0);
    sample();
    chk("rw_err", 64'(bus.err_o),  64'd1);
    chk("rw_busy", 64'(bus.busy_o), 64'd0);
    advance();

    // Randomized traffic against the model.
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 255) == 0);
      bus.req_i = 3'($urandom);
      bus.we_i  = 3'($urandom);
      bus.addr_i  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.wdata_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.be_i    = 24'($urandom);
      bus.size_i  = 6'($urandom);
      set_mem($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, {$urandom, $urandom});
      sample();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
